// File: rtl/ctrl_feed_sequencer.sv
// Feed sequencer: streams num_rows UB words into the diagonal skew stage,
// drains the skew pipe and pulses done; emits per-lane valids aligned with the skew.
// Ports: clk/rst (sync, active-high); start/base_addr/num_rows command;
//        busy/done status; ub_re/ub_addr UB read; feed_valid/feed_zero skew-input select;
//        lane_valid per-lane operand valid for the PE array.
module ctrl_feed_sequencer #(
  parameter int DATA_BW     = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int ADDRESSSIZE = 8,
  parameter int LEN_BW      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [LEN_BW-1:0]      num_rows,
  output logic                   busy,
  output logic                   done,
  output logic                   ub_re,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   feed_valid,
  output logic                   feed_zero,
  output logic [MATRIX_SIZE-1:0] lane_valid
);

  if (DATA_BW < 1 || MATRIX_SIZE < 2) begin : g_param_chk
    $error("ctrl_feed_sequencer: DATA_BW >= 1 and MATRIX_SIZE >= 2 required");
  end

  localparam int SR_W = MATRIX_SIZE - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] addr_q, addr_d;
  logic [LEN_BW-1:0]      cnt_q, cnt_d;
  logic [LEN_BW-1:0]      len_q, len_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   re_q, re_d;
  logic                   fv_q, fv_d;
  logic [SR_W-1:0]        sr_q, sr_d;
  logic [MATRIX_SIZE-1:0] lanes;
  logic                   drain_empty;

  // Lane M-1 takes feed_valid directly; lane i sits M-1-i flops deeper.
  assign lanes = {fv_q, sr_q};

  // Next cycle the shift register will be empty once lanes M-1..1 are clear.
  assign drain_empty = ((lanes >> 1) == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          addr_d  = base_addr;
          len_d   = num_rows;
          cnt_d   = '0;
          state_d = (num_rows != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        if (cnt_q == len_q - LEN_BW'(1)) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d  = cnt_q + LEN_BW'(1);
          addr_d = addr_q + ADDRESSSIZE'(1);
        end
      end
      S_DRAIN: begin
        if (drain_empty) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    re_d   = (state_d == S_FETCH);
    fv_d   = re_q;
    sr_d   = SR_W'(lanes >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      fv_q    <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      fv_q    <= fv_d;
      sr_q    <= sr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ub_re      = re_q;
  assign ub_addr    = addr_q;
  assign feed_valid = fv_q;
  assign feed_zero  = ~fv_q;
  assign lane_valid = lanes;

endmodule

// File: tb/tb_ctrl_feed_sequencer.sv
// Directed bench for ctrl_feed_sequencer.
// Expected waveforms come from closed-form cycle offsets relative to start.
module tb_ctrl_feed_sequencer;

  localparam int M = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] num_rows;
  logic       busy;
  logic       done;
  logic       ub_re;
  logic [7:0] ub_addr;
  logic       feed_valid;
  logic       feed_zero;
  logic [M-1:0] lane_valid;

  int total = 0;
  int bad   = 0;

  ctrl_feed_sequencer #(
    .DATA_BW(8), .MATRIX_SIZE(M), .ADDRESSSIZE(8), .LEN_BW(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .ub_re(ub_re), .ub_addr(ub_addr),
    .feed_valid(feed_valid), .feed_zero(feed_zero),
    .lane_valid(lane_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs t cycles after a start accepted with (base, n).
  task automatic expect_at(input int t, input logic [7:0] base,
                           input int n);
    logic         eb, ed, er, ef;
    logic [M-1:0] lv;
    logic [7:0]   ea;
    eb = (n != 0) && (t >= 1) && (t <= n + M);
    ed = (n == 0) ? (t == 1) : (t == n + M + 1);
    er = (t >= 1) && (t <= n);
    ef = (t >= 2) && (t <= n + 1);
    for (int i = 0; i < M; i++)
      lv[i] = (t >= 2 + (M-1-i)) && (t <= n + 1 + (M-1-i));
    ea = base + 8'(t - 1);
    chk($sformatf("busy@%0d", t), 32'(busy), 32'(eb));
    chk($sformatf("done@%0d", t), 32'(done), 32'(ed));
    chk($sformatf("ub_re@%0d", t), 32'(ub_re), 32'(er));
    chk($sformatf("fvalid@%0d", t), 32'(feed_valid), 32'(ef));
    chk($sformatf("fzero@%0d", t), 32'(feed_zero), 32'(!ef));
    chk($sformatf("lanes@%0d", t), 32'(lane_valid), 32'(lv));
    if (er) chk($sformatf("addr@%0d", t), 32'(ub_addr), 32'(ea));
  endtask

  task automatic expect_rst(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_re"}, 32'(ub_re), 32'd0);
    chk({tag, "_addr"}, 32'(ub_addr), 32'd0);
    chk({tag, "_fv"}, 32'(feed_valid), 32'd0);
    chk({tag, "_fz"}, 32'(feed_zero), 32'd1);
    chk({tag, "_lanes"}, 32'(lane_valid), 32'd0);
  endtask

  task automatic cmd(input logic [7:0] b, input logic [7:0] n);
    start     = 1'b1;
    base_addr = b;
    num_rows  = n;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = 8'h00;
    num_rows = 8'h00;
    step();
    step();
    expect_rst("reset");
    rst = 1'b0;
    step();
    expect_rst("idle");

    // N=4 at 0x10, ignored start at t=3, chained N=2 at 0x20 on done.
    cmd(8'h10, 8'd4);
    expect_at(0, 8'h10, 0 + 999);
    for (int t = 1; t <= 13; t++) begin
      step();
      start = 1'b0;
      if (t == 3) cmd(8'h40, 8'd7);
      if (t == 13) cmd(8'h20, 8'd2);
      expect_at(t, 8'h10, 4);
    end
    for (int t = 1; t <= 14; t++) begin
      step();
      start = 1'b0;
      expect_at(t, 8'h20, 2);
    end

    // Address wrap 0xFE, 0xFF, 0x00.
    cmd(8'hFE, 8'd3);
    for (int t = 1; t <= 14; t++) begin
      step();
      start = 1'b0;
      expect_at(t, 8'hFE, 3);
    end

    // Zero-length command.
    cmd(8'h77, 8'd0);
    for (int t = 1; t <= 4; t++) begin
      step();
      start = 1'b0;
      expect_at(t, 8'h77, 0);
    end

    // Reset in the middle of a run, then a fresh command.
    cmd(8'h30, 8'd4);
    for (int t = 1; t <= 4; t++) begin
      step();
      start = 1'b0;
      expect_at(t, 8'h30, 4);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_rst("mid_rst5");
    step();
    expect_rst("mid_rst6");
    for (int t = 7; t <= 14; t++) begin
      chk($sformatf("nodone@%0d", t), 32'(done), 32'd0);
      step();
    end
    cmd(8'h50, 8'd1);
    for (int t = 1; t <= 12; t++) begin
      step();
      start = 1'b0;
      expect_at(t, 8'h50, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
